spi_slave_shift_unit: RTL and testbench

SPI_SLAVE_SHIFT_UNIT -- requirements
Module: spi_slave_shift_unit

---
 rtl/spi_slave_shift_unit.sv | 137 +++++++++++++
 tb/tb_spi_slave_shift_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shift_unit.sv
// SPI slave RX/TX word shifters clocked on sclk; SPI_SLAVE_QUAD_EN enables 4-lane mode.
// rx_data_valid/tx_done register one edge after the last bit; no backpressure, cs high clears all state.
module spi_slave_shift_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  localparam int RX_DATA_WIDTH = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH,
  localparam int CW = $clog2(RX_DATA_WIDTH)
) (
  input  logic                     sclk,
  input  logic                     sys_rstn,
  input  logic                     cs,
  input  logic                     quad_en,
  input  logic [3:0]               sdi,
  output logic [3:0]               sdo,
  output logic [3:0]               sdo_oe,
  input  logic [CW-1:0]            rx_counter,
  input  logic                     rx_counter_upd,
  output logic [RX_DATA_WIDTH-1:0] rx_data,
  output logic                     rx_data_valid,
  input  logic [7:0]               tx_counter,
  input  logic                     tx_counter_upd,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     tx_data_valid,
  output logic                     tx_done
);

  localparam logic [CW-1:0] RX_CNT_RST = CW'(DATA_WIDTH - 1);
  localparam logic [7:0]    TX_CNT_RST = 8'(DATA_WIDTH - 1);

  logic quad;
`ifdef SPI_SLAVE_QUAD_EN
  assign quad = quad_en;
`else
  logic unused_quad;
  assign quad        = 1'b0;
  assign unused_quad = ^{quad_en, sdi[3:1]};
`endif

  logic [RX_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic [CW-1:0]            rx_cnt_q, rx_cnt_d, rx_target_q, rx_target_d, rx_eff;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [7:0]               tx_cnt_q, tx_cnt_d, tx_target_q, tx_target_d;
  logic                     tx_active_q, tx_active_d;
  logic                     tx_done_q, tx_done_d;

  // Receive path; cs high collapses every next-state to its reset value.
  always_comb begin
    rx_data_d   = '0;
    rx_valid_d  = 1'b0;
    rx_cnt_d    = RX_CNT_RST;
    rx_target_d = RX_CNT_RST;
    rx_eff      = rx_counter_upd ? rx_counter : rx_cnt_q;
    if (!cs) begin
      rx_target_d = rx_counter_upd ? rx_counter : rx_target_q;
      rx_data_d   = quad ? {rx_data_q[RX_DATA_WIDTH-5:0], sdi}
                         : {rx_data_q[RX_DATA_WIDTH-2:0], sdi[0]};
      if (rx_eff == '0) begin
        rx_valid_d = 1'b1;
        rx_cnt_d   = rx_target_d;
      end else begin
        rx_cnt_d   = rx_eff - CW'(1);
      end
    end
  end

  // Transmit path; a new load takes priority over both shifting and word end.
  always_comb begin
    shreg_d     = '0;
    tx_cnt_d    = TX_CNT_RST;
    tx_target_d = TX_CNT_RST;
    tx_active_d = 1'b0;
    tx_done_d   = 1'b0;
    if (!cs) begin
      shreg_d     = shreg_q;
      tx_cnt_d    = tx_cnt_q;
      tx_active_d = tx_active_q;
      tx_target_d = tx_counter_upd ? tx_counter : tx_target_q;
      tx_done_d   = tx_active_q && (tx_cnt_q == 8'd0);
      if (tx_data_valid) begin
        shreg_d     = tx_data;
        tx_cnt_d    = tx_target_d;
        tx_active_d = 1'b1;
      end else if (tx_active_q) begin
        if (tx_cnt_q != 8'd0) begin
          shreg_d  = quad ? (shreg_q << 4) : (shreg_q << 1);
          tx_cnt_d = tx_cnt_q - 8'd1;
        end else begin
          tx_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!sys_rstn) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_cnt_q    <= RX_CNT_RST;
      rx_target_q <= RX_CNT_RST;
      shreg_q     <= '0;
      tx_cnt_q    <= TX_CNT_RST;
      tx_target_q <= TX_CNT_RST;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_target_q <= rx_target_d;
      shreg_q     <= shreg_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_target_q <= tx_target_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  always_comb begin
    sdo    = '0;
    sdo_oe = '0;
    if (tx_active_q) begin
      if (quad) begin
        sdo    = shreg_q[DATA_WIDTH-1 -: 4];
        sdo_oe = 4'b1111;
      end else begin
        sdo    = {3'b000, shreg_q[DATA_WIDTH-1]};
        sdo_oe = 4'b0001;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = rx_valid_q;
  assign tx_done       = tx_done_q;

endmodule

// File: tb/tb_spi_slave_shift_unit.sv
// Bench for spi_slave_shift_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_spi_slave_shift_unit;

  localparam int DW = 8;
  localparam int RW = 12;
  localparam int CW = 4;

  logic          sclk = 1'b0;
  logic          sys_rstn, cs, quad_en;
  logic [3:0]    sdi, sdo, sdo_oe;
  logic [CW-1:0] rx_counter;
  logic          rx_counter_upd;
  logic [RW-1:0] rx_data;
  logic          rx_data_valid;
  logic [7:0]    tx_counter;
  logic          tx_counter_upd;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic          tx_done;

  spi_slave_shift_unit dut (
    .sclk(sclk), .sys_rstn(sys_rstn), .cs(cs), .quad_en(quad_en),
    .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_done(tx_done)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Reference model: RX as edges-remaining in a word, TX as a queue of symbols still to appear on sdo.
  logic [RW-1:0] m_rx_data;
  logic          m_rx_vld;
  int            m_rx_rem, m_rx_len;
  logic [3:0]    m_tx_q[$];
  int            m_tx_len;
  logic          m_tx_done;

  function automatic logic eff_quad();
`ifdef SPI_SLAVE_QUAD_EN
    return quad_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] symbol(input logic [DW-1:0] d, input int i, input int k);
    logic [31:0] v;
    v = ({24'b0, d} << (k * i)) & 32'hFF;
    return (k == 4) ? v[7:4] : {3'b000, v[7]};
  endfunction

  task automatic model_edge();
    int k;
    if (!sys_rstn || cs) begin
      m_rx_data = '0;
      m_rx_vld  = 1'b0;
      m_rx_len  = DW;
      m_rx_rem  = DW;
      m_tx_q.delete();
      m_tx_len  = DW;
      m_tx_done = 1'b0;
    end else begin
      k = eff_quad() ? 4 : 1;
      m_rx_data = RW'((32'(m_rx_data) << k) | ((k == 4) ? 32'(sdi) : 32'(sdi[0])));
      if (rx_counter_upd) begin
        m_rx_len = int'(rx_counter) + 1;
        m_rx_rem = m_rx_len;
      end
      m_rx_rem--;
      m_rx_vld = (m_rx_rem == 0);
      if (m_rx_rem == 0) m_rx_rem = m_rx_len;

      if (tx_counter_upd) m_tx_len = int'(tx_counter) + 1;
      m_tx_done = (m_tx_q.size() == 1);
      if (tx_data_valid) begin
        m_tx_q.delete();
        for (int i = 0; i < m_tx_len; i++) m_tx_q.push_back(symbol(tx_data, i, k));
      end else if (m_tx_q.size() > 0) begin
        void'(m_tx_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    logic [3:0] e_sdo, e_oe;
    @(posedge sclk);
    model_edge();
    #1;
    e_sdo = (m_tx_q.size() > 0) ? m_tx_q[0] : 4'h0;
    e_oe  = (m_tx_q.size() > 0) ? (eff_quad() ? 4'hF : 4'h1) : 4'h0;
    check("rx_data_valid", rx_data_valid, m_rx_vld);
    check("rx_data", rx_data, m_rx_data);
    check("sdo", sdo, e_sdo);
    check("sdo_oe", sdo_oe, e_oe);
    check("tx_done", tx_done, m_tx_done);
  endtask

  task automatic set_idle();
    cs = 1'b0; quad_en = 1'b0; sdi = 4'h0;
    rx_counter = '0; rx_counter_upd = 1'b0;
    tx_counter = '0; tx_counter_upd = 1'b0;
    tx_data = '0; tx_data_valid = 1'b0;
  endtask

  task automatic clear_cs();
    cs = 1'b1;
    tick();
    cs = 1'b0;
  endtask

  logic [7:0]  exp8;
  logic [11:0] exp12;

  initial begin
    set_idle();
    sys_rstn = 1'b0;
    repeat (3) tick();
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_data_valid, 0);
    check("rst_sdo", sdo, 0);
    check("rst_sdo_oe", sdo_oe, 0);
    check("rst_tx_done", tx_done, 0);
    sys_rstn = 1'b1;

    // Single-lane 8-bit receive of A5.
    exp8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sdi = {3'b000, exp8[7-i]};
      tick();
      if (i < 7) check("a5_early_valid", rx_data_valid, 0);
    end
    check("a5_valid", rx_data_valid, 1);
    check("a5_data", rx_data[7:0], 8'hA5);
    sdi = 4'h0;
    tick();
    check("a5_valid_one_cycle", rx_data_valid, 0);
    clear_cs();

    // 12-bit word with counter update on the first edge, then a second 12-edge word.
    exp12 = 12'h3C7;
    for (int i = 0; i < 12; i++) begin
      rx_counter_upd = (i == 0);
      rx_counter     = 4'd11;
      sdi = {3'b000, exp12[11-i]};
      tick();
      if (i == 10) check("w12_early_valid", rx_data_valid, 0);
    end
    rx_counter_upd = 1'b0;
    check("w12_valid", rx_data_valid, 1);
    check("w12_data", rx_data, 12'h3C7);
    for (int i = 0; i < 12; i++) begin
      sdi = 4'($urandom_range(1));
      tick();
      if (i == 10) check("w12b_early_valid", rx_data_valid, 0);
    end
    check("w12b_valid", rx_data_valid, 1);
    clear_cs();

    // Transmit C3, 8 edges.
    tx_data = 8'hC3; tx_data_valid = 1'b1; tx_counter_upd = 1'b1; tx_counter = 8'd7;
    exp8 = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      tick();
      tx_data_valid = 1'b0; tx_counter_upd = 1'b0;
      check($sformatf("c3_sdo%0d", i), sdo[0], exp8[7-i]);
      check("c3_oe", sdo_oe, 4'b0001);
      check("c3_nodone", tx_done, 0);
    end
    tick();
    check("c3_done", tx_done, 1);
    check("c3_oe_off", sdo_oe, 0);
    tick();
    check("c3_done_one_cycle", tx_done, 0);

    // Back-to-back: 81 loaded on the word-end edge of a prior word.
    tx_data = 8'h3C; tx_data_valid = 1'b1;
    tick();
    tx_data_valid = 1'b0;
    repeat (7) tick();
    tx_data = 8'h81; tx_data_valid = 1'b1;
    tick();
    tx_data_valid = 1'b0;
    check("b2b_done", tx_done, 1);
    check("b2b_oe", sdo_oe, 4'b0001);
    exp8 = 8'h81;
    check("b2b_sdo0", sdo[0], exp8[7]);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("b2b_sdo%0d", i), sdo[0], exp8[7-i]);
      if (i == 1) check("b2b_done_one_cycle", tx_done, 0);
    end
    tick();
    check("b2b_final_done", tx_done, 1);
    clear_cs();

`ifdef SPI_SLAVE_QUAD_EN
    quad_en = 1'b1;
    clear_cs();
    tx_data = 8'h5A; tx_data_valid = 1'b1; tx_counter_upd = 1'b1; tx_counter = 8'd1;
    rx_counter_upd = 1'b1; rx_counter = 4'd1; sdi = 4'h9;
    tick();
    check("quad_sdo_hi", sdo, 4'h5);
    check("quad_oe", sdo_oe, 4'hF);
    tx_data_valid = 1'b0; tx_counter_upd = 1'b0; rx_counter_upd = 1'b0; sdi = 4'h6;
    tick();
    check("quad_sdo_lo", sdo, 4'hA);
    check("quad_rx_valid", rx_data_valid, 1);
    check("quad_rx_data", rx_data[7:0], 8'h96);
    tick();
    check("quad_done", tx_done, 1);
    quad_en = 1'b0;
    clear_cs();
`else
    quad_en = 1'b1;
    tx_data = 8'h5A; tx_data_valid = 1'b1;
    tick();
    tx_data_valid = 1'b0;
    check("quad_off_oe", sdo_oe, 4'b0001);
    check("quad_off_sdo", sdo, 4'h0);
    quad_en = 1'b0;
    clear_cs();
`endif

    // Partial word discarded by cs, then a full FF word.
    sdi = 4'h1;
    repeat (3) tick();
    cs = 1'b1;
    tick();
    check("partial_no_valid", rx_data_valid, 0);
    cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) check("ff_early_valid", rx_data_valid, 0);
    end
    check("ff_valid", rx_data_valid, 1);
    check("ff_data", rx_data[7:0], 8'hFF);

    // Randomized traffic including resets, cs clears, aborts and counter updates.
    for (int c = 0; c < 3000; c++) begin
      sys_rstn = ($urandom_range(63) != 0);
      cs       = ($urandom_range(31) == 0);
      if (c % 200 == 0) begin
        quad_en = 1'($urandom_range(1));
        cs      = 1'b1;
      end
      sdi            = 4'($urandom);
      rx_counter_upd = ($urandom_range(15) == 0);
      rx_counter     = 4'($urandom);
      tx_data_valid  = ($urandom_range(9) == 0);
      tx_data        = 8'($urandom);
      tx_counter_upd = ($urandom_range(7) == 0);
      tx_counter     = 8'($urandom_range(15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
